ov_stream_gen: RTL and testbench
================================

Name: ov_stream_gen

Overview:
- Transmit side of the OV7670 DVP pixel interface.
- Emits ov_pclk, ov_vs, ov_hs and cam_data with sensor-like frame timing.
- Pixels come from a frame-buffer fetch port (or a built-in color bar pattern), sent as RGB565, two bytes per pixel.
- Drives the camera capture path in simulation/loopback and serves as an on-board camera stand-in.

Parameters:
WIDTH, 640, active pixels per line
HEIGHT, 480, active lines per frame
H_BLANK, 144, pclk periods with ov_hs low after each line's active bytes
VS_LINES, 3, line times with ov_vs high
V_BACK, 17, blank line times after VSYNC, before first active line
V_FRONT, 10, blank line times after last active line

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-low reset
work_en  input  1  enable streaming; sampled only at frame boundaries
use_pattern  input  1  select internal color bars (only with CAM_PATTERN_EN)
ov_pclk  output  1  pixel clock, clk/2
ov_vs  output  1  VSYNC, active high
ov_hs  output  1  HREF, high during active bytes
cam_data  output  8  pixel byte
pix_req  output  1  one-clk fetch strobe
pix_x  output  10  fetch column
pix_y  output  9  fetch row
pix_data  input  16  RGB565 pixel, valid on the clk after pix_req
frame_done  output  1  one-clk pulse at end of each frame
frame_cnt  output  16  frames completed, wraps at 65535

Behaviour:
- Reset (rst==0 on a clk edge):
  - All outputs 0; state IDLE.
  - Counters and the phase bit ph cleared.
  - Reset mid-frame aborts immediately; the next frame restarts from VSYNC.
- Pclk generation:
  - ov_pclk is a register; it toggles every clk while state != IDLE and holds 0 in IDLE.
  - A tick is a clk edge where ov_pclk==1.
  - On a tick: ov_pclk falls, and ov_vs/ov_hs/cam_data update together, so they are stable at the next ov_pclk rise.
- Line structure:
  - Line length L = 2*WIDTH + H_BLANK pclks; h_cnt runs 0..L-1.
  - Frame length = (VS_LINES + V_BACK + HEIGHT + V_FRONT) lines; v_cnt counts lines within the current state.
- States:
  - IDLE -> VSYNC on the first clk with work_en==1. ov_pclk starts toggling.
  - VSYNC: ov_vs=1, ov_hs=0, cam_data=0 for VS_LINES lines -> VBACK.
  - VBACK: ov_vs=0 for V_BACK lines -> ACTIVE.
  - ACTIVE, per line for HEIGHT lines:
    - h_cnt < 2*WIDTH: ov_hs=1; even h_cnt sends pix[15:8], odd h_cnt sends pix[7:0].
    - Otherwise ov_hs=0, cam_data=0.
    - After HEIGHT lines -> VFRONT.
  - VFRONT: V_FRONT lines.
    - On the final tick of the frame: frame_done pulses for one clk and frame_cnt increments.
    - Then -> VSYNC if work_en==1, else IDLE.
- work_en:
  - Deassertion mid-frame finishes the current frame.
  - Reassertion takes effect only at a frame boundary or from IDLE.
- Fetch:
  - pix_req pulses on the non-tick clk immediately before each even-h_cnt tick in ACTIVE.
  - pix_x = h_cnt/2, pix_y = active line index.
  - pix_data is captured on the following clk edge (the tick) into a 16-bit holding register. The high byte is output on that tick; the low byte on the next tick.
  - Exactly WIDTH*HEIGHT requests per frame; never any pix_req outside ACTIVE.
- Arithmetic:
  - Counters are sized with $clog2 of their maximum.
  - pix_x/pix_y are zero-extended or truncated to port width.
  - frame_cnt wraps mod 2^16.

Optional Feature:
- CAM_PATTERN_EN defined, use_pattern==1:
  - Pixel value comes from 8 vertical color bars, bar = pix_x*8/WIDTH.
  - Order: white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
  - pix_req stays 0.
- CAM_PATTERN_EN defined, use_pattern==0: fetch as normal.
- CAM_PATTERN_EN undefined: use_pattern is ignored and the pattern logic is absent.

Decomposition:
- Shared package cam_pkg:
  - State enum (IDLE, VSYNC, VBACK, ACTIVE, VFRONT).
  - RGB565 color constants.
  - Default timing constants (640/480/144/3/17/10).
- One sub-module, ov_color_bar: combinational map of pix_x to RGB565, instantiated only under CAM_PATTERN_EN.

Test Plan:
1. Bench parameters:
   - WIDTH=4, HEIGHT=2, H_BLANK=4, VS_LINES=1, V_BACK=1, V_FRONT=1.
   - Gives L=12 pclks and 5 lines (60 pclks, 120 clks) per frame.
2. Reset, work_en=1 -> ov_pclk toggles from the next clk; ov_vs high for exactly 12 pclks; first ov_hs rise 24 pclks after ov_vs rise; each ov_hs pulse 8 pclks; 2 pulses per frame.
3. pix_data = {pix_y[5:0], pix_x[9:0]} -> bytes sampled on ov_pclk rise are 00,00,00,01,00,02,00,03 on line 0 and 04,00,04,01,04,02,04,03 on line 1; 8 pix_req per frame.
4. Run 3 frames, drop work_en mid-frame 3 -> frame 3 completes; frame_cnt=3; frame_done pulsed 3 times, 120 clks apart; then IDLE with ov_pclk=0.
5. rst=0 during ACTIVE line 1 -> all outputs 0 the next clk; after release, with work_en=1, ov_vs rises with frame_cnt unchanged.
6. CAM_PATTERN_EN, use_pattern=1, WIDTH=8 -> line bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00; pix_req never asserted.

Source files
------------

// File: rtl/cam_pkg.sv
// cam_pkg: shared FSM states, RGB565 color constants and default OV7670 timing
// for the DVP stream generator.
package cam_pkg;
    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;
    localparam int DEF_WIDTH    = 640;
    localparam int DEF_HEIGHT   = 480;
    localparam int DEF_H_BLANK  = 144;
    localparam int DEF_VS_LINES = 3;
    localparam int DEF_V_BACK   = 17;
    localparam int DEF_V_FRONT  = 10;
    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;
    function automatic logic [15:0] bar_color(input logic [2:0] bar);
        return bar == 3'd0 ? RGB_WHITE :
               bar == 3'd1 ? RGB_YELLOW :
               bar == 3'd2 ? RGB_CYAN :
               bar == 3'd3 ? RGB_GREEN :
               bar == 3'd4 ? RGB_MAGENTA :
               bar == 3'd5 ? RGB_RED :
               bar == 3'd6 ? RGB_BLUE : RGB_BLACK;
    endfunction
endpackage

// File: rtl/ov_color_bar.sv
// ov_color_bar: maps a pixel column onto eight equal-width vertical RGB565 bars.
module ov_color_bar
    import cam_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [9:0]  x_i,
    output logic [15:0] rgb_o
);
    logic [2:0] bar;
    always_comb bar = 3'((32'(x_i) * 8) / WIDTH);
    always_comb rgb_o = bar_color(bar);
endmodule

// File: rtl/ov_stream_gen.sv
// ov_stream_gen: OV7670-style DVP transmitter producing pclk, VSYNC, HREF and RGB565 bytes.
// Define CAM_PATTERN_EN to add the built-in color bar source selected by use_pattern.
module ov_stream_gen
    import cam_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int HEIGHT   = DEF_HEIGHT,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int VS_LINES = DEF_VS_LINES,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int V_FRONT  = DEF_V_FRONT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        work_en,
    input  logic        use_pattern,
    output logic        ov_pclk,
    output logic        ov_vs,
    output logic        ov_hs,
    output logic [7:0]  cam_data,
    output logic        pix_req,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    input  logic [15:0] pix_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);
    localparam int L    = 2 * WIDTH + H_BLANK;
    localparam int HW   = $clog2(L);
    localparam int VM_A = VS_LINES > V_BACK ? VS_LINES : V_BACK;
    localparam int VM_B = HEIGHT > V_FRONT ? HEIGHT : V_FRONT;
    localparam int VW   = $clog2((VM_A > VM_B ? VM_A : VM_B) + 1);
    localparam logic [HW-1:0] H_LAST = HW'(L - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(2 * WIDTH);
    localparam logic [VW-1:0] VS_END = VW'(VS_LINES - 1);
    localparam logic [VW-1:0] VB_END = VW'(V_BACK - 1);
    localparam logic [VW-1:0] VA_END = VW'(HEIGHT - 1);
    localparam logic [VW-1:0] VF_END = VW'(V_FRONT - 1);
    state_t state_q, state_d;
    logic pclk_q, pclk_d, vs_q, vs_d, hs_q, hs_d, req_q, req_d, done_q, done_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d, v_end;
    logic [7:0] data_q, data_d, lo_q, lo_d;
    logic [9:0] x_q, x_d, cur_x;
    logic [8:0] y_q, y_d;
    logic [15:0] cnt_q, cnt_d, pix;
    logic pat, in_act, line_end, frame_end;
    assign cur_x = 10'(h_q >> 1);
`ifdef CAM_PATTERN_EN
    logic [15:0] bar_rgb;
    ov_color_bar #(.WIDTH(WIDTH)) u_bar (.x_i(cur_x), .rgb_o(bar_rgb));
    assign pat = use_pattern;
    assign pix = pat ? bar_rgb : pix_data;
`else
    logic unused_pattern;
    assign unused_pattern = use_pattern;
    assign pat = 1'b0;
    assign pix = pix_data;
`endif
    assign in_act    = state_q == ACTIVE && h_q < H_ACT;
    assign line_end  = h_q == H_LAST;
    assign frame_end = pclk_q && state_q == VFRONT && line_end && v_q == VF_END;
    assign v_end = state_q == VSYNC ? VS_END : state_q == VBACK ? VB_END :
                   state_q == ACTIVE ? VA_END : VF_END;
    // Ticks (pclk high) advance the raster; the clk before an even tick issues the fetch.
    always_comb begin
        state_d = state_q;
        pclk_d  = state_q != IDLE && !pclk_q;
        h_d     = h_q;
        v_d     = v_q;
        vs_d    = vs_q;
        hs_d    = hs_q;
        data_d  = data_q;
        lo_d    = lo_q;
        req_d   = 1'b0;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (work_en) state_d = VSYNC;
        end else if (!pclk_q) begin
            req_d = !pat && in_act && !h_q[0];
            if (req_d) begin
                x_d = cur_x;
                y_d = 9'(v_q);
            end
        end else begin
            vs_d   = state_q == VSYNC;
            hs_d   = in_act;
            data_d = !in_act ? 8'h00 : h_q[0] ? lo_q : pix[15:8];
            if (in_act && !h_q[0]) lo_d = pix[7:0];
            h_d = line_end ? '0 : h_q + 1'b1;
            if (line_end) begin
                v_d = v_q == v_end ? '0 : v_q + 1'b1;
                if (v_q == v_end)
                    state_d = state_q == VSYNC ? VBACK : state_q == VBACK ? ACTIVE :
                              state_q == ACTIVE ? VFRONT : work_en ? VSYNC : IDLE;
            end
            if (frame_end) begin
                done_d = 1'b1;
                cnt_d  = cnt_q + 16'd1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            pclk_q  <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            data_q  <= '0;
            lo_q    <= '0;
            req_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pclk_q  <= pclk_d;
            h_q     <= h_d;
            v_q     <= v_d;
            vs_q    <= vs_d;
            hs_q    <= hs_d;
            data_q  <= data_d;
            lo_q    <= lo_d;
            req_q   <= req_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end
    assign ov_pclk    = pclk_q;
    assign ov_vs      = vs_q;
    assign ov_hs      = hs_q;
    assign cam_data   = data_q;
    assign pix_req    = req_q;
    assign pix_x      = x_q;
    assign pix_y      = y_q;
    assign frame_done = done_q;
    assign frame_cnt  = cnt_q;
endmodule

// File: tb/tb_ov_stream_gen.sv
// tb_ov_stream_gen: checks frame timing, fetched bytes, work_en handling, mid-frame reset
// and (with CAM_PATTERN_EN) the color bar source against a tick-indexed raster model.
module tb_ov_stream_gen;
    localparam int W = 4, H = 2, HB = 4, VSL = 1, VB = 1, VF = 1, PW = 8;
    localparam int L = 2 * W + HB;
    localparam int FL = (VSL + VB + H + VF) * L;
    logic clk = 0, rst = 0, work_en = 0, use_pattern = 0;
    logic [15:0] pix_data = '0;
    logic ov_pclk, ov_vs, ov_hs, pix_req, frame_done;
    logic [7:0] cam_data;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic [15:0] frame_cnt;
    int errors = 0, checks = 0;
    int cyc = 0, req_n = 0, done_n = 0;
    int done_t[$];
    ov_stream_gen #(.WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .VS_LINES(VSL), .V_BACK(VB), .V_FRONT(VF)) dut (
        .clk(clk), .rst(rst), .work_en(work_en), .use_pattern(use_pattern),
        .ov_pclk(ov_pclk), .ov_vs(ov_vs), .ov_hs(ov_hs), .cam_data(cam_data),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );
`ifdef CAM_PATTERN_EN
    logic p_pclk, p_vs, p_hs, p_req, p_done;
    logic [7:0] p_data;
    logic [9:0] p_x;
    logic [8:0] p_y;
    logic [15:0] p_cnt;
    ov_stream_gen #(.WIDTH(PW), .HEIGHT(H), .H_BLANK(HB), .VS_LINES(VSL), .V_BACK(VB), .V_FRONT(VF)) u_pat (
        .clk(clk), .rst(rst), .work_en(work_en), .use_pattern(use_pattern),
        .ov_pclk(p_pclk), .ov_vs(p_vs), .ov_hs(p_hs), .cam_data(p_data),
        .pix_req(p_req), .pix_x(p_x), .pix_y(p_y), .pix_data(pix_data),
        .frame_done(p_done), .frame_cnt(p_cnt)
    );
`endif
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Frame-buffer stand-in: answers every fetch with {row, column}.
    always @(negedge clk) begin
        pix_data <= {pix_y[5:0], pix_x};
        if (pix_req) req_n <= req_n + 1;
        if (frame_done) begin
            done_n <= done_n + 1;
            done_t.push_back(cyc);
        end
    end
    // Expected {vs, hs, byte} emitted on raster tick t of a frame.
    function automatic logic [9:0] exp_tick(input int t);
        int line, h, y;
        logic act;
        logic [15:0] px;
        line = t / L;
        h    = t % L;
        y    = line - VSL - VB;
        act  = line >= VSL + VB && line < VSL + VB + H && h < 2 * W;
        px   = {6'(y), 10'(h / 2)};
        return {line < VSL, act, act ? ((h % 2) ? px[7:0] : px[15:8]) : 8'h00};
    endfunction
    task automatic next_rise(output logic [9:0] s, output bit ok);
        ok = 0;
        s  = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ov_pclk) begin
                s  = {ov_vs, ov_hs, cam_data};
                ok = 1;
                return;
            end
        end
    endtask
    task automatic test_reset;
        rst = 0;
        work_en = 0;
        use_pattern = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ov_pclk, ov_vs, ov_hs, cam_data, pix_req, pix_x, pix_y, frame_done, frame_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got pclk=%b vs=%b hs=%b data=%h req=%b x=%0d y=%0d done=%b cnt=%0d, expected all 0",
                     ov_pclk, ov_vs, ov_hs, cam_data, pix_req, pix_x, pix_y, frame_done, frame_cnt);
        end
    endtask
    task automatic test_stream;
        logic [9:0] s[$];
        logic [9:0] v;
        bit ok;
        int r0, vs_hi, vs_rise, hs_rise, hs_pulses, hs_len, t0, pclk_hi;
        rst = 1;
        work_en = 1;
        @(negedge clk);
        checks++;
        if (ov_pclk !== 1'b0) begin errors++; $display("FAIL pclk_first: got %b expected 0", ov_pclk); end
        @(negedge clk);
        checks++;
        if (ov_pclk !== 1'b1) begin errors++; $display("FAIL pclk_toggle: got %b expected 1", ov_pclk); end
        r0 = req_n;
        s.push_back({ov_vs, ov_hs, cam_data});
        for (int k = 1; k <= FL; k++) begin
            next_rise(v, ok);
            if (!ok) begin
                checks++; errors++;
                $display("FAIL pclk_timeout: no pclk rise at sample %0d", k);
                break;
            end
            s.push_back(v);
        end
        checks++;
        if (s[0] !== 10'h000) begin errors++; $display("FAIL sample0: got %h expected 000", s[0]); end
        vs_hi = 0; vs_rise = -1; hs_rise = -1; hs_pulses = 0; hs_len = 0;
        for (int k = 1; k < s.size(); k++) begin
            checks++;
            if (s[k] !== exp_tick(k - 1)) begin
                errors++;
                $display("FAIL tick_%0d: got vs/hs/data=%h expected %h", k - 1, s[k], exp_tick(k - 1));
            end
            if (s[k][9]) vs_hi++;
            if (s[k][9] && !s[k-1][9] && vs_rise < 0) vs_rise = k;
            if (s[k][8]) hs_len++;
            if (s[k][8] && !s[k-1][8]) begin
                if (hs_rise < 0) hs_rise = k;
                hs_pulses++;
            end
        end
        checks++;
        if (vs_hi != VSL * L) begin errors++; $display("FAIL vs_width: got %0d expected %0d", vs_hi, VSL * L); end
        checks++;
        if (hs_rise - vs_rise != (VSL + VB) * L) begin errors++; $display("FAIL hs_offset: got %0d expected %0d", hs_rise - vs_rise, (VSL + VB) * L); end
        checks++;
        if (hs_pulses != H || hs_len != H * 2 * W) begin errors++; $display("FAIL hs_pulses: got %0d pulses %0d high, expected %0d and %0d", hs_pulses, hs_len, H, H * 2 * W); end
        #1;
        checks++;
        if (req_n - r0 != W * H) begin errors++; $display("FAIL req_frame1: got %0d expected %0d", req_n - r0, W * H); end
        checks++;
        if (frame_cnt !== 16'd1) begin errors++; $display("FAIL cnt_frame1: got %0d expected 1", frame_cnt); end
        for (int i = 0; i < 400 && done_n < 2; i++) begin @(negedge clk); #1; end
        repeat (50) @(negedge clk);
        work_en = 0;
        for (int i = 0; i < 400 && done_n < 3; i++) begin @(negedge clk); #1; end
        checks++;
        if (done_n != 3 || frame_cnt !== 16'd3) begin errors++; $display("FAIL three_frames: got done=%0d cnt=%0d expected 3 and 3", done_n, frame_cnt); end
        checks++;
        if (done_t.size() != 3 || done_t[1] - done_t[0] != 2 * FL || done_t[2] - done_t[1] != 2 * FL) begin
            errors++;
            $display("FAIL done_spacing: got %0d pulses, gaps %0d %0d, expected %0d", done_t.size(),
                     done_t.size() > 1 ? done_t[1] - done_t[0] : -1, done_t.size() > 2 ? done_t[2] - done_t[1] : -1, 2 * FL);
        end
        t0 = req_n;
        pclk_hi = 0;
        repeat (2 * FL + 10) begin
            @(negedge clk);
            if (ov_pclk) pclk_hi++;
        end
        #1;
        checks++;
        if (pclk_hi != 0 || done_n != 3 || req_n != t0) begin
            errors++;
            $display("FAIL idle_after: got pclk_high=%0d done=%0d new_req=%0d expected 0 3 0", pclk_hi, done_n, req_n - t0);
        end
        checks++;
        if (t0 - r0 != 3 * W * H) begin errors++; $display("FAIL req_total: got %0d expected %0d", t0 - r0, 3 * W * H); end
    endtask
    task automatic test_reset_mid;
        bit found = 0;
        int n = 0;
        work_en = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (pix_req && pix_y == 9'd1) begin found = 1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL reach_line1: no fetch on line 1 seen"); end
        rst = 0;
        @(negedge clk);
        checks++;
        if ({ov_pclk, ov_vs, ov_hs, cam_data, pix_req, pix_x, pix_y, frame_done, frame_cnt} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got pclk=%b vs=%b hs=%b data=%h req=%b x=%0d y=%0d done=%b cnt=%0d, expected all 0",
                     ov_pclk, ov_vs, ov_hs, cam_data, pix_req, pix_x, pix_y, frame_done, frame_cnt);
        end
        rst = 1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ov_vs) begin n = i; break; end
        end
        checks++;
        if (n != 3) begin errors++; $display("FAIL restart_vs: vs rose after %0d clks expected 3", n); end
        checks++;
        if (frame_cnt !== 16'd0 || ov_hs !== 1'b0) begin errors++; $display("FAIL restart_state: got cnt=%0d hs=%b expected 0 0", frame_cnt, ov_hs); end
    endtask
`ifdef CAM_PATTERN_EN
    task automatic test_pattern;
        logic [7:0] got[$];
        logic [15:0] bars [8];
        logic [15:0] c;
        int reqs = 0;
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        rst = 0; work_en = 0; use_pattern = 1;
        repeat (3) @(negedge clk);
        rst = 1; work_en = 1;
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            if (p_req) reqs++;
            if (p_pclk && p_hs) got.push_back(p_data);
        end
        checks++;
        if (got.size() != H * 2 * PW) begin errors++; $display("FAIL pattern_len: got %0d bytes expected %0d", got.size(), H * 2 * PW); end
        for (int i = 0; i < got.size() && i < H * 2 * PW; i++) begin
            c = bars[((i % (2 * PW)) / 2) * 8 / PW];
            checks++;
            if (got[i] !== ((i % 2) ? c[7:0] : c[15:8])) begin
                errors++;
                $display("FAIL pattern_byte_%0d: got %h expected %h", i, got[i], (i % 2) ? c[7:0] : c[15:8]);
            end
        end
        checks++;
        if (reqs != 0) begin errors++; $display("FAIL pattern_req: got %0d requests expected 0", reqs); end
        use_pattern = 0;
    endtask
`else
    task automatic test_pattern_ignored;
        logic [7:0] got[$];
        logic [15:0] px;
        int reqs = 0;
        rst = 0; work_en = 0; use_pattern = 1;
        repeat (3) @(negedge clk);
        rst = 1; work_en = 1;
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            if (pix_req) reqs++;
            if (ov_pclk && ov_hs) got.push_back(cam_data);
        end
        checks++;
        if (reqs != W * H) begin errors++; $display("FAIL ignore_req: got %0d expected %0d", reqs, W * H); end
        checks++;
        if (got.size() != H * 2 * W) begin errors++; $display("FAIL ignore_len: got %0d expected %0d", got.size(), H * 2 * W); end
        for (int i = 0; i < got.size() && i < H * 2 * W; i++) begin
            px = {6'(i / (2 * W)), 10'((i % (2 * W)) / 2)};
            checks++;
            if (got[i] !== ((i % 2) ? px[7:0] : px[15:8])) begin
                errors++;
                $display("FAIL ignore_byte_%0d: got %h expected %h", i, got[i], (i % 2) ? px[7:0] : px[15:8]);
            end
        end
        use_pattern = 0;
    endtask
`endif
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        test_reset();
        test_stream();
        test_reset_mid();
`ifdef CAM_PATTERN_EN
        test_pattern();
`else
        test_pattern_ignored();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
